// File: rtl/seg_pipe_approx_adder.sv
// Segmented, pipelined N-bit adder with per-transaction exact / lower-part-OR approximate mode.
// An exact carry chain runs alongside the selected one and sets err when the two results differ.
module seg_pipe_approx_adder #(
    parameter int unsigned N   = 8,
    parameter int unsigned SEG = 4,
    parameter int unsigned K   = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         err
);

    localparam int unsigned STAGES = N / SEG;
    localparam int unsigned MID    = (STAGES > 1) ? STAGES - 1 : 1;

    if ((N % SEG) != 0) begin : g_bad_seg
        $error("seg_pipe_approx_adder: N must be a multiple of SEG");
    end
    if (K > N) begin : g_bad_k
        $error("seg_pipe_approx_adder: K must be in 0..N");
    end

    // a/b shift right as segments are consumed; sum shifts in finished segments from the top
    typedef struct packed {
        logic         vld;
        logic         mode;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] s;
        logic         ca;
        logic         ce;
        logic         mis;
    } stage_t;

    logic                    adv_c;
    stage_t                  in_st;
    stage_t [STAGES-1:0]     prv;
    stage_t [MID-1:0]        st_d;
    stage_t [MID-1:0]        st_q;
    stage_t                  cur;
    stage_t                  nxt;
    logic [N-1:0]            ta;
    logic [N-1:0]            tb;
    logic [SEG-1:0]          seg;
    logic                    ca;
    logic                    ce;
    logic                    ai;
    logic                    bi;
    logic                    sb;
    logic                    ex;
    logic                    vld_d, vld_q;
    logic [N-1:0]            sum_d, sum_q;
    logic                    cout_d, cout_q;
    logic                    err_d, err_q;

    assign adv_c    = ~vld_q | out_ready;
    assign in_ready = adv_c;

    always_comb begin
        in_st      = '0;
        in_st.vld  = in_valid;
        in_st.mode = mode;
        in_st.a    = A;
        in_st.b    = B;
    end

    if (STAGES > 1) begin : g_skew
        assign prv = {st_q, in_st};
    end else begin : g_flat
        assign prv = in_st;
    end

    // One SEG-bit slice per stage: selected (approx/exact) chain plus reference exact chain
    always_comb begin
        st_d   = '0;
        cur    = '0;
        nxt    = '0;
        ta     = '0;
        tb     = '0;
        seg    = '0;
        ca     = 1'b0;
        ce     = 1'b0;
        ai     = 1'b0;
        bi     = 1'b0;
        sb     = 1'b0;
        ex     = 1'b0;
        vld_d  = 1'b0;
        sum_d  = '0;
        cout_d = 1'b0;
        err_d  = 1'b0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            cur = prv[s];
            nxt = cur;
            ta  = cur.a;
            tb  = cur.b;
            ca  = cur.ca;
            ce  = cur.ce;
            seg = '0;
            for (int unsigned j = 0; j < SEG; j++) begin
                ai = ta[0];
                bi = tb[0];
                ta = ta >> 1;
                tb = tb >> 1;
                ex = ai ^ bi ^ ce;
                ce = (ai & bi) | (ce & (ai ^ bi));
                if (cur.mode && ((s * SEG + j) < K)) begin
                    sb = ai | bi;
                    ca = ai & bi;
                end else begin
                    sb = ai ^ bi ^ ca;
                    ca = (ai & bi) | (ca & (ai ^ bi));
                end
                seg     = (seg >> 1) | (SEG'(sb) << (SEG - 1));
                nxt.mis = nxt.mis | (sb ^ ex);
            end
            nxt.a  = ta;
            nxt.b  = tb;
            nxt.s  = (cur.s >> SEG) | (N'(seg) << (N - SEG));
            nxt.ca = ca;
            nxt.ce = ce;
            if (s < STAGES - 1) begin
                st_d[s] = nxt;
            end else begin
                vld_d  = nxt.vld;
                sum_d  = nxt.s;
                cout_d = ca;
                err_d  = nxt.mode & (nxt.mis | (ca ^ ce));
            end
        end
    end

    // Whole pipe, bubbles included, moves only on adv_c
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= '0;
            vld_q  <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (adv_c) begin
            st_q   <= st_d;
            vld_q  <= vld_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            err_q  <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seg_pipe_approx_adder.sv
// Scoreboard bench for seg_pipe_approx_adder: directed cases, stream, backpressure,
// mid-flight reset, and random sweeps on two extra parameter sets.
module tb_seg_pipe_approx_adder;

    logic        clk;
    logic        rst;
    int          cyc;
    int          n_chk;
    int          n_fail;
    bit          lat_chk;

    // main instance N=8 SEG=4 K=4
    logic        iv, ir, m, ov, ordy, co, er;
    logic [7:0]  a, b, s;
    // N=16 SEG=4 K=6
    logic        iv16, ir16, m16, ov16, or16, co16, er16;
    logic [15:0] a16, b16, s16;
    // N=8 SEG=8 K=0
    logic        iv0, ir0, m0, ov0, or0, co0, er0;
    logic [7:0]  a0, b0, s0;

    logic [17:0] q_main[$];
    int          q_cyc[$];
    logic [17:0] q16[$];
    logic [17:0] q0[$];

    logic [17:0] e_main, e16, e0;
    int          c_main;

    seg_pipe_approx_adder #(.N(8), .SEG(4), .K(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .A(a), .B(b), .mode(m),
        .out_valid(ov), .out_ready(ordy), .sum(s), .cout(co), .err(er)
    );

    seg_pipe_approx_adder #(.N(16), .SEG(4), .K(6)) u_dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16), .mode(m16),
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .err(er16)
    );

    seg_pipe_approx_adder #(.N(8), .SEG(8), .K(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0), .mode(m0),
        .out_valid(ov0), .out_ready(or0), .sum(s0), .cout(co0), .err(er0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Reference: returns {err, cout, sum[15:0]}
    function automatic logic [17:0] model(input int unsigned n, input int unsigned k,
                                          input logic [15:0] x, input logic [15:0] y,
                                          input logic md);
        logic [16:0] ex, ap, lo, wmask, smask;
        logic        c;
        wmask = (17'd1 << (n + 1)) - 17'd1;
        smask = (17'd1 << n) - 17'd1;
        ex = (17'(x) + 17'(y)) & wmask;
        if (md && k > 0) begin
            lo = 17'(x | y) & ((17'd1 << k) - 17'd1);
            c  = x[k-1] & y[k-1];
            ap = ((((17'(x) >> k) + (17'(y) >> k) + 17'(c)) << k) | lo) & wmask;
        end else begin
            ap = ex;
        end
        return {ap != ex, ap[n], 16'(ap & smask)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitors: pop on every completed output handshake
    always @(negedge clk) begin
        if (!rst && ov && ordy) begin
            n_chk++;
            assert (q_main.size() > 0) else begin
                n_fail++;
                $error("FAIL main_unexpected observed=sum %0h expected=no output", s);
            end
            if (q_main.size() > 0) begin
                e_main = q_main.pop_front();
                c_main = q_cyc.pop_front();
                chk("main_sum", 32'(s), 32'(e_main[7:0]));
                chk("main_cout", 32'(co), 32'(e_main[16]));
                chk("main_err", 32'(er), 32'(e_main[17]));
                if (lat_chk) chk("main_latency", 32'(cyc - c_main), 32'd2);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov16 && or16) begin
            n_chk++;
            assert (q16.size() > 0) else begin
                n_fail++;
                $error("FAIL n16_unexpected observed=sum %0h expected=no output", s16);
            end
            if (q16.size() > 0) begin
                e16 = q16.pop_front();
                chk("n16_sum", 32'(s16), 32'(e16[15:0]));
                chk("n16_cout", 32'(co16), 32'(e16[16]));
                chk("n16_err", 32'(er16), 32'(e16[17]));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ov0 && or0) begin
            n_chk++;
            assert (q0.size() > 0) else begin
                n_fail++;
                $error("FAIL k0_unexpected observed=sum %0h expected=no output", s0);
            end
            if (q0.size() > 0) begin
                e0 = q0.pop_front();
                chk("k0_sum", 32'(s0), 32'(e0[7:0]));
                chk("k0_cout", 32'(co0), 32'(e0[16]));
                chk("k0_err_zero", 32'(er0), 32'd0);
            end
        end
    end

    // Drive one transaction on the main instance and wait for its acceptance
    task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tm);
        logic rdy;
        int   acc;
        bit   done;
        done = 1'b0;
        iv = 1'b1;
        a  = ta;
        b  = tb;
        m  = tm;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            rdy = ir;
            acc = cyc;
            @(posedge clk);
            if (rdy) begin
                q_main.push_back(model(8, 4, {8'h00, ta}, {8'h00, tb}, tm));
                q_cyc.push_back(acc);
                done = 1'b1;
            end
            #1;
        end
        n_chk++;
        assert (done) else begin
            n_fail++;
            $error("FAIL send_timeout observed=not accepted expected=accepted");
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && (q_main.size() + q16.size() + q0.size()) != 0; t++)
            @(posedge clk);
        #1;
        chk("main_drained", 32'(q_main.size()), 32'd0);
        chk("n16_drained", 32'(q16.size()), 32'd0);
        chk("k0_drained", 32'(q0.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] ss;
        logic       sc, se, r16, r0;
        int         sent16, sent0;
        cyc = 0; n_chk = 0; n_fail = 0; lat_chk = 1'b1;
        rst = 1'b1;
        iv = 1'b0; a = '0; b = '0; m = 1'b0; ordy = 1'b1;
        iv16 = 1'b0; a16 = '0; b16 = '0; m16 = 1'b0; or16 = 1'b1;
        iv0 = 1'b0; a0 = '0; b0 = '0; m0 = 1'b0; or0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_sum", 32'(s), 32'd0);
        chk("rst_cout", 32'(co), 32'd0);
        chk("rst_err", 32'(er), 32'd0);
        chk("rst_in_ready", 32'(ir), 32'd1);
        @(posedge clk); #1;

        // directed vectors
        send(8'h0F, 8'h01, 1'b0);
        send(8'h0F, 8'h01, 1'b1);
        send(8'h88, 8'h88, 1'b1);
        send(8'h12, 8'h21, 1'b1);
        send(8'hFF, 8'hFF, 1'b0);
        send(8'hFF, 8'hFF, 1'b1);
        iv = 1'b0;
        drain();

        // back-to-back stream
        for (int i = 0; i < 16; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        iv = 1'b0;
        drain();

        // backpressure
        lat_chk = 1'b0;
        ordy = 1'b0;
        send(8'h3C, 8'h5A, 1'b1);
        send(8'h81, 8'h7F, 1'b0);
        iv = 1'b1; a = 8'h99; b = 8'h66; m = 1'b1;
        @(negedge clk);
        chk("bp_out_valid", 32'(ov), 32'd1);
        ss = s; sc = co; se = er;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(ir), 32'd0);
            chk("bp_sum_hold", 32'(s), 32'(ss));
            chk("bp_cout_hold", 32'(co), 32'(sc));
            chk("bp_err_hold", 32'(er), 32'(se));
        end
        @(posedge clk); #1;
        ordy = 1'b1;
        send(8'h99, 8'h66, 1'b1);
        iv = 1'b0;
        drain();

        // reset with two transactions in flight
        ordy = 1'b0;
        send(8'h44, 8'h44, 1'b0);
        send(8'h55, 8'h0A, 1'b1);
        iv = 1'b0;
        rst = 1'b1;
        q_main.delete();
        q_cyc.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", 32'(ov), 32'd0);
        chk("mid_rst_sum", 32'(s), 32'd0);
        ordy = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("mid_rst_no_stale", 32'(ov), 32'd0);
        end
        @(posedge clk); #1;
        lat_chk = 1'b1;
        send(8'h01, 8'h01, 1'b0);
        iv = 1'b0;
        drain();

        // random sweeps with random valid and out_ready on both extra instances
        sent16 = 0; sent0 = 0;
        for (int t = 0; t < 8000 && (sent16 < 1000 || sent0 < 1000 || iv16 || iv0); t++) begin
            @(negedge clk);
            r16 = ir16;
            r0  = ir0;
            @(posedge clk);
            if (iv16 && r16) begin
                q16.push_back(model(16, 6, a16, b16, m16));
                sent16++;
            end
            if (iv0 && r0) begin
                q0.push_back(model(8, 0, {8'h00, a0}, {8'h00, b0}, m0));
                sent0++;
            end
            #1;
            iv16 = (sent16 < 1000) && ($urandom_range(0, 7) != 0);
            a16  = 16'($urandom);
            b16  = 16'($urandom);
            m16  = 1'($urandom_range(0, 1));
            or16 = ($urandom_range(0, 3) != 0);
            iv0  = (sent0 < 1000) && ($urandom_range(0, 7) != 0);
            a0   = 8'($urandom);
            b0   = 8'($urandom);
            m0   = 1'($urandom_range(0, 1));
            or0  = ($urandom_range(0, 3) != 0);
        end
        iv16 = 1'b0; iv0 = 1'b0; or16 = 1'b1; or0 = 1'b1;
        chk("n16_sent", 32'(sent16), 32'd1000);
        chk("k0_sent", 32'(sent0), 32'd1000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_pipe_approx_adder.md
Name: seg_pipe_approx_adder

Overview:
- Parametrised, pipelined N-bit adder with a per-transaction mode select: exact addition, or LOA-style approximation of the low K bits.
- Operands are split into SEG-bit segments, with one pipeline stage per segment and carry/operand skew registers between stages.
- An exact reference carry chain runs alongside the approximate one, so every result carries an error flag. This gives the error-characterisation benches a cycle-accurate, streaming approximate adder with valid/ready handshakes.

Parameters:
- N, 8, operand/sum width; must be a multiple of SEG (elaboration error otherwise).
- SEG, 4, bits added per pipeline stage; STAGES = N/SEG.
- K, 4, number of approximated low bits, 0..N; K=0 means approx mode equals exact.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands/mode valid.
- in_ready  output  1  block accepts input this cycle.
- A  input  N  operand A.
- B  input  N  operand B.
- mode  input  1  0 = exact, 1 = approximate low K bits.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  N  result (exact or approximate per captured mode).
- cout  output  1  carry out of bit N-1 of the selected result.
- err  output  1  1 when the selected result {cout,sum} differs from the exact {cout,sum}; always 0 for mode=0.

Behaviour:
- Reset: all stage valid bits clear; out_valid=0, sum=0, cout=0, err=0. in_ready is 1 in the cycle after reset deasserts. Asserting rst mid-operation discards all in-flight transactions in that cycle and produces no output for them.
- Global advance: adv = !out_valid | out_ready. in_ready = adv (combinational). All stage registers load only when adv=1. When adv=0 every stage holds, including bubbles.
- Acceptance: a transfer occurs on a clock edge with in_valid & in_ready. Mode is captured with its operands and travels with the transaction.
- Latency: the result appears at out_valid exactly STAGES cycles after acceptance when out_ready stays high. Throughput is one result per cycle.
- Stage s (0..STAGES-1) handles bits [s*SEG +: SEG], using the carry registered from stage s-1 (stage 0 carry-in = 0). Unprocessed upper operand bits and completed lower sum bits are skewed through registers.
- Approximate rule (mode=1):
  - For bit i < K: sum[i] = A[i] | B[i].
  - Carry into bit K = A[K-1] & B[K-1] (0 if K=0).
  - Bits ≥ K: exact ripple addition.
  - If K=N, then cout = A[N-1] & B[N-1].
- Exact rule (mode=0): {cout,sum} = A + B, mod 2^(N+1).
- Exact chain: every stage also carries an exact carry and accumulates a sticky per-transaction mismatch bit. err = mismatch & mode at output.
- K may straddle segment boundaries; a stage can contain both approximate and exact bits.
- Output registers hold their value while out_valid & !out_ready; they must not change until the handshake completes.
- in_valid may drop with a transaction in flight; resulting bubbles propagate and produce no out_valid.
- Simultaneous output handshake and input accept in the same cycle is legal, with no lost or duplicated transaction.
- Bit-exact equivalence at K=0: err is always 0 and sum equals A+B in both modes.

Test Plan:
- Settings N=8, SEG=4, K=4 unless noted.
- Exact add: A=0x0F, B=0x01, mode=0 -> after 2 cycles sum=0x10, cout=0, err=0.
- Approx with loss: A=0x0F, B=0x01, mode=1 -> sum=0x0F, cout=0, err=1. A=0x88, B=0x88, mode=1 -> sum=0x18, cout=1, err=1 (exact result is 0x10, cout=1).
- Approx, no loss: A=0x12, B=0x21, mode=1 -> sum=0x33, cout=0, err=0. A=0xFF, B=0xFF, mode=0 -> sum=0xFE, cout=1, err=0.
- Back-to-back stream:
  - Input: 16 consecutive random transactions with mixed mode, out_ready=1.
  - Required: 16 results in order, at one per cycle, starting 2 cycles after the first accept. Each result matches the reference model.
- Backpressure:
  - Input: 3 transactions; hold out_ready=0 for 5 cycles, then release.
  - Required: in_ready=0 once out_valid is asserted. sum/cout/err stay stable while stalled, and all 3 results are delivered in order with no loss or duplication.
- Reset mid-flight:
  - Input: assert rst for 1 cycle with 2 transactions in flight.
  - Required: next cycle out_valid=0, sum=0, and no stale result ever emerges. A new transaction A=0x01, B=0x01, mode=0 then yields sum=0x02 after 2 cycles.
- Parameter sweep: (N=16, SEG=4, K=6) and (N=8, SEG=8, K=0), 1000 random vectors each -> all results match the model. For K=0, err=0 always.
